// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter:
//   - default values for the arbiter / multiplier parameters
//   - architecture selector codes understood by the shared multiplier
//   - the arbiter FSM state encoding
package mult_arbiter_pkg;

  localparam int DEF_PARALLELISM = 8;
  localparam int DEF_N_REQ       = 4;
  localparam int DEF_ARCH_TYPE   = 2;

  // Multiplier architecture codes
  localparam int ARCH_BEHAVIOURAL = 0;
  localparam int ARCH_CARRY_SAVE  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mult_arbiter_multiplier.sv
// Combinational unsigned multiplier shared by all requesters.
// Ports:
//   multiplicand_i [parallelism-1:0]   unsigned operand A
//   multiplier_i   [parallelism-1:0]   unsigned operand B
//   product_o      [2*parallelism-1:0] full-width unsigned product
// ARCH_TYPE == ARCH_CARRY_SAVE builds a carry-save array of partial products
// with one final carry-propagate add; any other value uses the native '*'.
module multiplier
  import mult_arbiter_pkg::*;
#(
  parameter int parallelism = DEF_PARALLELISM,
  parameter int ARCH_TYPE   = DEF_ARCH_TYPE
) (
  input  logic [parallelism-1:0]   multiplicand_i,
  input  logic [parallelism-1:0]   multiplier_i,
  output logic [2*parallelism-1:0] product_o
);

  localparam int PW = 2 * parallelism;

  generate
    if (ARCH_TYPE == ARCH_CARRY_SAVE) begin : g_csa
      logic [PW-1:0] sum_v;
      logic [PW-1:0] carry_v;
      logic [PW-1:0] pp_v;
      logic [PW-1:0] sum_n;

      // Each partial product is folded into a redundant (sum, carry) pair with
      // a 3:2 compressor; carries out of the top bit are dropped because the
      // true product always fits in PW bits, so arithmetic mod 2^PW is exact.
      always_comb begin
        sum_v   = '0;
        carry_v = '0;
        pp_v    = '0;
        sum_n   = '0;
        for (int i = 0; i < parallelism; i++) begin
          pp_v    = multiplier_i[i] ? (PW'(multiplicand_i) << i) : '0;
          sum_n   = sum_v ^ carry_v ^ pp_v;
          carry_v = ((sum_v & carry_v) | (sum_v & pp_v) | (carry_v & pp_v)) << 1;
          sum_v   = sum_n;
        end
        product_o = sum_v + carry_v;
      end
    end else begin : g_beh
      assign product_o = PW'(multiplicand_i) * PW'(multiplier_i);
    end
  endgenerate

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared unsigned multiplier.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid        [N_REQ]         per-requester operation request
//   req_multiplicand [N_REQ][P]      per-requester operand A
//   req_multiplier   [N_REQ][P]      per-requester operand B
//   req_ready        [N_REQ]         one-hot acceptance strobe (IDLE only)
//   res_valid / res_ready            result handshake
//   res_product      [2P]            product of the granted requester
//   res_id           [clog2(N_REQ)]  index of the requester owning the result
//   busy                             high whenever not IDLE
// One operation takes IDLE (grant) -> CALC (multiply) -> HOLD (present result).
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int PARALLELISM = DEF_PARALLELISM,
  parameter int N_REQ       = DEF_N_REQ,
  parameter int ARCH_TYPE   = DEF_ARCH_TYPE
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][PARALLELISM-1:0]   req_multiplicand,
  input  logic [N_REQ-1:0][PARALLELISM-1:0]   req_multiplier,
  output logic [N_REQ-1:0]                    req_ready,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [2*PARALLELISM-1:0]            res_product,
  output logic [$clog2(N_REQ)-1:0]            res_id,
  output logic                                busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int PW    = 2 * PARALLELISM;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       res_id_q, res_id_d;
  logic [PARALLELISM-1:0] a_q, a_d;
  logic [PARALLELISM-1:0] b_q, b_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic [PW-1:0]          mult_p;

  logic                   gnt_found;
  logic [IDX_W-1:0]       gnt_idx;
  logic [IDX_W-1:0]       cidx;
  int                     cand;

  // Round-robin search starting at ptr_q, which always holds the index after
  // the last grant, so that requester has top priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = IDX_W'(cand);
      if (!gnt_found && req_valid[cidx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cidx;
      end
    end
  end

  multiplier #(
    .parallelism(PARALLELISM),
    .ARCH_TYPE  (ARCH_TYPE)
  ) u_mult (
    .multiplicand_i(a_q),
    .multiplier_i  (b_q),
    .product_o     (mult_p)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    res_id_d  = res_id_q;
    req_ready = '0;
    case (state_q)
      // Grant stage: accept one requester and capture its operands
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          a_d     = req_multiplicand[gnt_idx];
          b_d     = req_multiplier[gnt_idx];
          idx_d   = gnt_idx;
          ptr_d   = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          state_d = CALC;
        end
      end
      // Multiply stage: register the product and its owner
      CALC: begin
        prod_d   = mult_p;
        res_id_d = idx_q;
        state_d  = HOLD;
      end
      // Result stage: hold until the consumer takes it
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // No acceptance may be signalled while the block is being reset.
    if (!rst_n) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      prod_q   <= '0;
      res_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      prod_q   <= prod_d;
      res_id_q <= res_id_d;
    end
  end

  // Operand and owner latches only matter once CALC is entered; no reset needed.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    idx_q <= idx_d;
  end

  assign res_valid   = (state_q == HOLD);
  assign busy        = (state_q != IDLE);
  assign res_product = prod_q;
  assign res_id      = res_id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int P = 8;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0][P-1:0] mcand;
  logic [N-1:0][P-1:0] mplier;
  logic [N-1:0]        req_ready;
  logic                res_valid;
  logic                res_ready;
  logic [2*P-1:0]      res_product;
  logic [1:0]          res_id;
  logic                busy;

  always #5 clk = ~clk;

  mult_arbiter #(
    .PARALLELISM(P),
    .N_REQ      (N),
    .ARCH_TYPE  (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_multiplicand(mcand),
    .req_multiplier  (mplier),
    .req_ready       (req_ready),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_product     (res_product),
    .res_id          (res_id),
    .busy            (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int id;
    int prod;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result handshake happens.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
        chk("result_was_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("mon_res_id", 32'(res_id), mon_e.id);
          chk("mon_res_product", 32'(res_product), mon_e.prod);
        end
      end
    end
  end

  // One full operation: grant, CALC, HOLD (+ stall cycles), retire.
  task automatic run_op(input logic [N-1:0] vld, input logic [N-1:0] gnt,
                        input int id, input int prod, input int stall);
    @(negedge clk);
    req_valid = vld;
    res_ready = 1'b0;
    #1;
    chk("grant", 32'(req_ready), 32'(gnt));
    chk("busy_idle", 32'(busy), 32'd0);
    exp_q.push_back('{id: id, prod: prod});
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    chk("calc_req_ready", 32'(req_ready), 32'd0);
    chk("calc_res_valid", 32'(res_valid), 32'd0);
    chk("calc_busy", 32'(busy), 32'd1);
    @(negedge clk);
    res_ready = (stall == 0);
    #1;
    chk("hold_res_valid", 32'(res_valid), 32'd1);
    chk("hold_req_ready", 32'(req_ready), 32'd0);
    chk("hold_product", 32'(res_product), prod);
    chk("hold_id", 32'(res_id), id);
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      res_ready = (s == stall);
      #1;
      chk("stall_res_valid", 32'(res_valid), 32'd1);
      chk("stall_product", 32'(res_product), prod);
      chk("stall_id", 32'(res_id), id);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    mcand     = '0;
    mplier    = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_product", 32'(res_product), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    rst_n = 1'b1;

    // Single request: 3*5
    mcand[0] = 8'd3;  mplier[0] = 8'd5;
    run_op(4'b0001, 4'b0001, 0, 15, 0);

    // No request in IDLE: nothing moves
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
    chk("idle_product", 32'(res_product), 32'd15);
    chk("idle_id", 32'(res_id), 32'd0);

    // Reset during CALC discards the operation
    mcand[2] = 8'd12; mplier[2] = 8'd11;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("rmid_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("rmid_busy_calc", 32'(busy), 32'd1);
    chk("rmid_ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rmid_res_valid", 32'(res_valid), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_product", 32'(res_product), 32'd0);
    chk("rmid_id", 32'(res_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rmid_no_result", 32'(res_valid), 32'd0);

    // Contention with all requesters held; pointer restarted at 0
    mcand[0] = 8'd3;  mplier[0] = 8'd5;
    mcand[1] = 8'd7;  mplier[1] = 8'd9;
    mcand[2] = 8'd12; mplier[2] = 8'd11;
    mcand[3] = 8'd20; mplier[3] = 8'd13;
    run_op(4'b1111, 4'b0001, 0, 15, 0);
    run_op(4'b1111, 4'b0010, 1, 63, 5);
    run_op(4'b1111, 4'b0100, 2, 132, 0);
    run_op(4'b1111, 4'b1000, 3, 260, 0);
    run_op(4'b1111, 4'b0001, 0, 15, 0);

    // Wrap: after a grant to 3, index 0 comes before 3
    run_op(4'b1000, 4'b1000, 3, 260, 0);
    run_op(4'b1001, 4'b0001, 0, 15, 0);
    run_op(4'b1001, 4'b1000, 3, 260, 0);

    // Operand extremes
    mcand[0] = 8'd255; mplier[0] = 8'd255;
    mcand[1] = 8'd0;   mplier[1] = 8'd200;
    mcand[2] = 8'd128; mplier[2] = 8'd2;
    run_op(4'b0001, 4'b0001, 0, 65025, 0);
    run_op(4'b0010, 4'b0010, 1, 0, 0);
    run_op(4'b0100, 4'b0100, 2, 256, 0);

    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("end_res_valid", 32'(res_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
